// File: rtl/afe_pkg.sv
// Shared definitions for the AFE hit TDC: result-word layout, FSM states,
// parameter defaults and the word packing helper.
package afe_pkg;

    localparam int CNT_WIDTH_DEF  = 12;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int WORD_W  = 16;
    localparam int HIT_BIT = 15;
    localparam int SAT_BIT = 14;
    localparam int LAT_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_WAIT_LOW = 2'd2
    } afe_state_e;

    function automatic logic [WORD_W-1:0] pack_word(input logic hit,
                                                    input logic sat,
                                                    input logic [LAT_W-1:0] lat);
        logic [WORD_W-1:0] w;
        w            = '0;
        w[HIT_BIT]   = hit;
        w[SAT_BIT]   = sat;
        w[LAT_W-1:0] = lat;
        return w;
    endfunction

endpackage

// File: rtl/afe_hit_tdc_if.sv
// Result read port of the hit TDC: first-word-fall-through head plus status.
interface afe_hit_tdc_if;
    import afe_pkg::*;

    logic              RD_EN;
    logic [WORD_W-1:0] DATA;
    logic              EMPTY;
    logic              FULL;

    modport master (output RD_EN, input DATA, EMPTY, FULL);
    modport slave  (input RD_EN, output DATA, EMPTY, FULL);

endinterface

// File: rtl/afe_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO without
// a simultaneous pop is dropped and reported on drop_o.
module afe_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign drop_o    = push_i & full_o & ~pop_i;
    assign data_o    = mem_q[rd_ptr_q];

    // Occupancy next state from the accepted push/pop pair
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers (natural power-of-two wrap) and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/afe_hit_tdc.sv
// Measures injection-to-hit latency from asynchronous AFE strobes and queues
// one result word per injection, with a saturating hit counter.
module afe_hit_tdc
    import afe_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         CLK,
    input  logic         RST_B,
    input  logic         INJ,
    input  logic         HIT,
    input  logic         CLEAR,
    afe_hit_tdc_if.slave rd_bus,
    output logic         LOST,
    output logic [15:0]  HIT_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0]           inj_sync_q, hit_sync_q;
    logic [1:0]           sync_vld_q;
    logic                 inj_armed_q, inj_armed_d;
    afe_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic                 sat_q, sat_d, sat_inc_s, hit_q, hit_d;
    logic                 lost_q, lost_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic                 inj_rise_s, inj_fall_s, hit_rise_s;
    logic                 push_s, hit_push_s, drop_s;
    logic [WORD_W-1:0]    push_word_s;

    // Bit [1] is the synchronized level, bit [2] its previous value. An INJ
    // already high out of reset is not armed until it has been seen low.
    assign inj_rise_s  = inj_sync_q[1] & ~inj_sync_q[2] & inj_armed_q;
    assign inj_fall_s  = ~inj_sync_q[1] & inj_sync_q[2];
    assign hit_rise_s  = hit_sync_q[1] & ~hit_sync_q[2];
    assign inj_armed_d = inj_armed_q | (sync_vld_q[1] & ~inj_sync_q[1]);

    assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign sat_inc_s  = sat_q | (cnt_q == CNT_MAX);
    assign hit_push_s = push_s & push_word_s[HIT_BIT];

    // Measurement FSM: next state, counter/flags and the result push
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        hit_d       = hit_q;
        push_s      = 1'b0;
        push_word_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (inj_rise_s) begin
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    hit_d   = hit_rise_s;
                    state_d = hit_rise_s ? ST_WAIT_LOW : ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                cnt_d = cnt_inc_s;
                sat_d = sat_inc_s;
                if (inj_fall_s) begin
                    push_s      = 1'b1;
                    push_word_s = pack_word(1'b0, sat_inc_s, LAT_W'(cnt_inc_s));
                    state_d     = ST_IDLE;
                end else if (hit_rise_s) begin
                    hit_d   = 1'b1;
                    state_d = ST_WAIT_LOW;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_WAIT_LOW: begin
                if (inj_fall_s) begin
                    push_s      = 1'b1;
                    push_word_s = pack_word(1'b1, sat_q, LAT_W'(cnt_q));
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hit counter and sticky loss flag; CLEAR still counts a coincident hit
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        lost_d    = lost_q;
        if (CLEAR) begin
            hit_cnt_d = {15'd0, hit_push_s};
            lost_d    = drop_s;
        end else begin
            if (hit_push_s && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                hit_cnt_d = hit_cnt_q;
            end
            lost_d = lost_q | drop_s;
        end
    end

    // Synchronizers and all state registers
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            inj_sync_q  <= 3'b000;
            hit_sync_q  <= 3'b000;
            sync_vld_q  <= 2'b00;
            inj_armed_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            hit_q       <= 1'b0;
            lost_q      <= 1'b0;
            hit_cnt_q   <= 16'd0;
        end else begin
            inj_sync_q  <= {inj_sync_q[1:0], INJ};
            hit_sync_q  <= {hit_sync_q[1:0], HIT};
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            inj_armed_q <= inj_armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            hit_q       <= hit_d;
            lost_q      <= lost_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    afe_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_n_i     (RST_B),
        .push_i      (push_s),
        .push_data_i (push_word_s),
        .pop_i       (rd_bus.RD_EN),
        .data_o      (rd_bus.DATA),
        .empty_o     (rd_bus.EMPTY),
        .full_o      (rd_bus.FULL),
        .drop_o      (drop_s)
    );

    assign LOST    = lost_q;
    assign HIT_CNT = hit_cnt_q;

endmodule

// File: tb/tb_afe_hit_tdc.sv
// Directed bench for afe_hit_tdc: latency words, saturation, FIFO full/drop,
// simultaneous push/pop, CLEAR and reset-during-measurement behaviour.
module tb_afe_hit_tdc;
    import afe_pkg::*;

    logic        CLK   = 1'b0;
    logic        RST_B = 1'b0;
    logic        INJ   = 1'b0;
    logic        HIT   = 1'b0;
    logic        CLEAR = 1'b0;
    logic        LOST;
    logic [15:0] HIT_CNT;

    int n_checks = 0;
    int n_errors = 0;

    afe_hit_tdc_if rd_if ();

    afe_hit_tdc dut (
        .CLK     (CLK),
        .RST_B   (RST_B),
        .INJ     (INJ),
        .HIT     (HIT),
        .CLEAR   (CLEAR),
        .rd_bus  (rd_if),
        .LOST    (LOST),
        .HIT_CNT (HIT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // hit_at < 0: no hit; mode 1 pulses RD_EN, mode 2 pulses CLEAR on the push edge
    task automatic inject(input int hit_at, input int fall_at, input int mode);
        @(negedge CLK);
        INJ = 1'b1;
        if (hit_at == 0) HIT = 1'b1;
        for (int c = 1; c <= fall_at; c++) begin
            @(negedge CLK);
            if (c == hit_at) HIT = 1'b1;
        end
        INJ = 1'b0;
        HIT = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        if (mode == 1) rd_if.RD_EN = 1'b1;
        if (mode == 2) CLEAR = 1'b1;
        @(negedge CLK);
        rd_if.RD_EN = 1'b0;
        CLEAR       = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check_eq(tag, {16'd0, rd_if.DATA}, {16'd0, exp});
        rd_if.RD_EN = 1'b1;
        @(negedge CLK);
        rd_if.RD_EN = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rd_if.RD_EN = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_empty", {31'd0, rd_if.EMPTY}, 32'd1);
        check_eq("rst_full", {31'd0, rd_if.FULL}, 32'd0);
        check_eq("rst_data", {16'd0, rd_if.DATA}, 32'h0000);
        check_eq("rst_lost", {31'd0, LOST}, 32'd0);
        check_eq("rst_hitcnt", {16'd0, HIT_CNT}, 32'd0);
        RST_B = 1'b1;
        repeat (3) @(negedge CLK);

        inject(25, 40, 0);
        check_eq("hit25_empty", {31'd0, rd_if.EMPTY}, 32'd0);
        check_eq("hit25_cnt", {16'd0, HIT_CNT}, 32'd1);
        pop_check("hit25_word", 16'h8019);
        check_eq("hit25_drained", {31'd0, rd_if.EMPTY}, 32'd1);

        inject(-1, 100, 0);
        check_eq("nohit_cnt", {16'd0, HIT_CNT}, 32'd1);
        pop_check("nohit_word", 16'h0064);

        inject(0, 10, 0);
        check_eq("same_edge_cnt", {16'd0, HIT_CNT}, 32'd2);
        pop_check("same_edge_word", 16'h8000);

        // HIT activity with INJ low must not start anything
        @(negedge CLK);
        HIT = 1'b1;
        repeat (8) @(negedge CLK);
        HIT = 1'b0;
        repeat (6) @(negedge CLK);
        check_eq("idle_hit_empty", {31'd0, rd_if.EMPTY}, 32'd1);
        check_eq("idle_hit_cnt", {16'd0, HIT_CNT}, 32'd2);

        inject(4500, 5000, 0);
        check_eq("sat_cnt", {16'd0, HIT_CNT}, 32'd3);
        pop_check("sat_word", 16'hCFFF);

        inject(5, 12, 2);
        check_eq("clear_with_hit", {16'd0, HIT_CNT}, 32'd1);
        pop_check("clear_with_hit_word", 16'h8005);
        pulse_clear();
        check_eq("clear_cnt", {16'd0, HIT_CNT}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            inject(-1, 10 + i, 0);
            if (i == 2) check_eq("three_not_full", {31'd0, rd_if.FULL}, 32'd0);
            if (i == 3) check_eq("four_full", {31'd0, rd_if.FULL}, 32'd1);
            if (i == 3) check_eq("four_not_lost", {31'd0, LOST}, 32'd0);
        end
        check_eq("overflow_lost", {31'd0, LOST}, 32'd1);
        check_eq("overflow_full", {31'd0, rd_if.FULL}, 32'd1);
        pop_check("ovf_pop0", 16'h000A);
        pop_check("ovf_pop1", 16'h000B);
        pop_check("ovf_pop2", 16'h000C);
        pop_check("ovf_pop3", 16'h000D);
        check_eq("ovf_drained", {31'd0, rd_if.EMPTY}, 32'd1);

        // RD_EN on an empty FIFO is ignored
        rd_if.RD_EN = 1'b1;
        repeat (2) @(negedge CLK);
        rd_if.RD_EN = 1'b0;
        check_eq("empty_pop_empty", {31'd0, rd_if.EMPTY}, 32'd1);
        check_eq("empty_pop_full", {31'd0, rd_if.FULL}, 32'd0);

        pulse_clear();
        check_eq("clear_lost", {31'd0, LOST}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            inject(-1, 20 + i, 0);
        end
        check_eq("pp_full", {31'd0, rd_if.FULL}, 32'd1);
        inject(-1, 24, 1);
        check_eq("pp_lost", {31'd0, LOST}, 32'd0);
        check_eq("pp_still_full", {31'd0, rd_if.FULL}, 32'd1);
        pop_check("pp_pop0", 16'h0015);
        pop_check("pp_pop1", 16'h0016);
        pop_check("pp_pop2", 16'h0017);
        pop_check("pp_pop3", 16'h0018);
        check_eq("pp_drained", {31'd0, rd_if.EMPTY}, 32'd1);

        // Reset in the middle of a measurement, released with INJ still high
        @(negedge CLK);
        INJ = 1'b1;
        repeat (20) @(negedge CLK);
        RST_B = 1'b0;
        repeat (2) @(negedge CLK);
        RST_B = 1'b1;
        repeat (20) @(negedge CLK);
        check_eq("midrst_empty", {31'd0, rd_if.EMPTY}, 32'd1);
        INJ = 1'b0;
        repeat (10) @(negedge CLK);
        check_eq("midrst_fall_empty", {31'd0, rd_if.EMPTY}, 32'd1);
        inject(-1, 30, 0);
        check_eq("midrst_fresh_empty", {31'd0, rd_if.EMPTY}, 32'd0);
        pop_check("midrst_fresh_word", 16'h001E);
        check_eq("midrst_final_empty", {31'd0, rd_if.EMPTY}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/afe_hit_tdc.md
AFE_HIT_TDC -- requirements
Module: afe_hit_tdc

Interface
REQ-001 Parameter CNT_WIDTH, default 12: width of the injection-to-hit latency counter.
REQ-002 Parameter FIFO_DEPTH, default 4: number of result words buffered; power of two.
REQ-003 CLK  input  1  single system clock; all logic on its rising edge.
REQ-004 RST_B  input  1  reset, synchronous and active-low.
REQ-005 INJ  input  1  asynchronous injection strobe, taken from the AFE injection output.
REQ-006 HIT  input  1  asynchronous latched comparator hit from the AFE; cleared by the AFE when INJ falls.
REQ-007 CLEAR  input  1  synchronous one-cycle clear of the hit counter and LOST flag.
REQ-008 RD_EN  input  1  pops the FIFO head when EMPTY is low.
REQ-009 DATA  output  16  FIFO head word: [15] hit seen, [14] latency saturated, [13:12] zero, [11:0] latency.
REQ-010 EMPTY  output  1  FIFO holds no words.
REQ-011 FULL  output  1  FIFO holds FIFO_DEPTH words.
REQ-012 LOST  output  1  sticky flag: at least one result word was dropped.
REQ-013 HIT_CNT  output  16  saturating count of injections that produced a hit.

Function
REQ-014 INJ and HIT SHALL each pass through a two-flop synchronizer; edges SHALL be detected on the synchronized signals only.
REQ-015 FSM states SHALL be IDLE, COUNT and WAIT_LOW.
REQ-016 IDLE -> COUNT on the INJ rising edge: latency counter loads 0 and the hit flag clears.
REQ-017 In COUNT the counter SHALL increment by 1 per cycle and saturate at 2^CNT_WIDTH-1, setting the saturated flag.
REQ-018 COUNT -> WAIT_LOW on the HIT rising edge: the counter freezes and the hit flag sets.
REQ-019 If the INJ and HIT rising edges land in the same cycle, the FSM SHALL take IDLE -> WAIT_LOW with latency 0 and the hit flag set.
REQ-020 On the INJ falling edge in COUNT or WAIT_LOW, the FSM SHALL push one word {hit, sat, 2'b00, counter} and return to IDLE.
REQ-021 A word pushed from COUNT SHALL carry hit=0 and the counter value at the INJ fall.
REQ-022 HIT edges in IDLE SHALL be ignored.
REQ-023 A new INJ rise in the same cycle as the push SHALL be ignored; the FSM only leaves IDLE on the following edge.
REQ-024 HIT_CNT SHALL increment on every push with hit=1 and saturate at 0xFFFF.
REQ-025 The FIFO SHALL be first-word-fall-through: DATA is valid whenever EMPTY is low, and RD_EN advances it on the next edge.
REQ-026 A push while FULL with no simultaneous pop SHALL drop the word and set LOST.
REQ-027 A push and a pop in the same cycle while FULL SHALL both succeed; occupancy is unchanged.
REQ-028 A push and a pop in the same cycle while EMPTY SHALL store the word; EMPTY falls on the next cycle.
REQ-029 RD_EN while EMPTY SHALL be ignored.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 CLEAR SHALL zero HIT_CNT and LOST only; it SHALL NOT affect the FIFO or the FSM.
REQ-032 If CLEAR and a hit push occur in the same cycle, HIT_CNT SHALL read 1 afterwards.

Reset
REQ-033 With RST_B low at a CLK edge, the block SHALL:
- set the FSM to IDLE;
- empty the FIFO (EMPTY=1, FULL=0);
- clear DATA=0x0000, LOST=0, HIT_CNT=0, the counter and the synchronizers.
REQ-034 A reset during COUNT or WAIT_LOW SHALL abandon the measurement without a push.
REQ-035 After reset, an INJ already high SHALL NOT start a measurement until it falls and rises again.

Structure
REQ-036 A shared package afe_pkg SHALL hold:
- the word field positions;
- the FSM state enumeration;
- the CNT_WIDTH and FIFO_DEPTH defaults.
REQ-037 The FIFO SHALL be a separate sub-module, afe_sync_fifo, parameterized on width and depth.

Verification
REQ-038 INJ rise; HIT rise 25 cycles later; INJ fall at 40 -> one word 0x8019; HIT_CNT=1.
REQ-039 INJ high 100 cycles with no HIT -> word 0x0064; HIT_CNT unchanged.
REQ-040 INJ high 5000 cycles, HIT at 4500 -> word 0xCFFF.
REQ-041 Five injections with no reads -> FULL=1 after the fourth; fifth dropped; LOST=1; four pops return the first four words in order.
REQ-042 FULL, with RD_EN asserted in the cycle of a fifth push -> LOST stays 0; the fifth word is read last.
REQ-043 RST_B low mid-COUNT, then released with INJ still high -> no word pushed; EMPTY=1 until a fresh INJ rise/fall cycle.
